eth_tx_sequencer: RTL



---
 rtl/eth_tx_sequencer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_sequencer.sv
// eth_tx_sequencer
//   APB master that packs a byte stream into 32-bit words, writes them into
//   the hazard3_ethernet TX buffer, then writes TX size, issues the send
//   command and polls TX-ready.
//
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     s_valid, s_data, s_last,        byte stream in (accepted on
//     s_ready                         s_valid && s_ready)
//     psel, penable, pwrite,          APB master
//     paddr, pwdata, prdata,
//     pready, pslverr
//     busy                            frame in progress
//     done                            one-cycle pulse, frame sent cleanly
//     err                             sticky: 0 none, 1 oversize,
//                                     2 slave error, 3 poll timeout
//
//   Optional build macro ETH_TXSEQ_STATS_EN adds frames_ok, frames_err and
//   bytes_ok counters.
module eth_tx_sequencer #(
    parameter int unsigned MTU        = 1536,
    parameter int unsigned POLL_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
`ifdef ETH_TXSEQ_STATS_EN
   ,output logic [15:0] frames_ok,
    output logic [15:0] frames_err,
    output logic [31:0] bytes_ok
`endif
);

    localparam int unsigned PW        = $clog2(POLL_LIMIT + 1);
    localparam logic [15:0] ADDR_SIZE = 16'(MTU);
    localparam logic [15:0] ADDR_SEND = 16'(MTU + 8);
    localparam logic [15:0] ADDR_STAT = 16'(MTU + 12);

    typedef enum logic [2:0] {
        IDLE, COLLECT, WR_BUF, WR_SIZE, WR_SEND, POLL, GAP, DONE
    } state_t;

    state_t         state;
    logic [15:0]    byte_cnt;
    logic [15:0]    waddr;
    logic [31:0]    word;
    logic [1:0]     held;
    logic           last_word;
    logic           discard;
    logic [PW-1:0]  poll_cnt;

    logic           accept;
    logic [31:0]    word_nxt;
    logic [15:0]    setup_addr;
    logic [31:0]    setup_data;
    logic           prdata_unused;

    always_comb begin
        accept        = s_valid && s_ready;
        prdata_unused = ^prdata[31:1];
        word_nxt      = word;
        word_nxt[{held, 3'b000} +: 8] = s_data;
    end

    // Address/data presented on SETUP for the control-register states.
    always_comb begin
        setup_addr = waddr;
        setup_data = pwdata;
        case (state)
            WR_SIZE: begin setup_addr = ADDR_SIZE; setup_data = {16'h0000, byte_cnt}; end
            WR_SEND: begin setup_addr = ADDR_SEND; setup_data = '0; end
            POLL:    begin setup_addr = ADDR_STAT; setup_data = '0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 2'd0;
            byte_cnt  <= '0;
            waddr     <= '0;
            word      <= '0;
            held      <= '0;
            last_word <= 1'b0;
            discard   <= 1'b0;
            poll_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        state    <= COLLECT;
                        err      <= 2'd0;
                        byte_cnt <= '0;
                        waddr    <= '0;
                        word     <= '0;
                        held     <= '0;
                        discard  <= 1'b0;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (discard || byte_cnt == ADDR_SIZE) begin
                            // Byte beyond MTU: flag once, swallow through s_last.
                            discard <= 1'b1;
                            err     <= 2'd1;
                            if (s_last) begin
                                s_ready <= 1'b0;
                                busy    <= 1'b0;
                                state   <= DONE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 16'd1;
                            if (held == 2'd3 || s_last) begin
                                // SETUP is issued on entry so the word write
                                // starts as soon as the word is complete.
                                s_ready   <= 1'b0;
                                last_word <= s_last;
                                state     <= WR_BUF;
                                psel      <= 1'b1;
                                penable   <= 1'b0;
                                pwrite    <= 1'b1;
                                paddr     <= waddr;
                                pwdata    <= word_nxt;
                                word      <= '0;
                                held      <= '0;
                            end else begin
                                word <= word_nxt;
                                held <= held + 2'd1;
                            end
                        end
                    end
                end
                WR_BUF, WR_SIZE, WR_SEND, POLL: begin
                    if (!psel) begin
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= (state != POLL);
                        paddr   <= setup_addr;
                        pwdata  <= setup_data;
                    end else if (!penable) begin
                        penable <= 1'b1;
                    end else if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            err   <= 2'd2;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            case (state)
                                WR_BUF: begin
                                    waddr <= waddr + 16'd4;
                                    if (last_word) begin
                                        state <= WR_SIZE;
                                    end else begin
                                        state   <= COLLECT;
                                        s_ready <= 1'b1;
                                    end
                                end
                                WR_SIZE: state <= WR_SEND;
                                WR_SEND: begin
                                    state    <= POLL;
                                    poll_cnt <= '0;
                                end
                                POLL: begin
                                    if (prdata[0]) begin
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                        state <= DONE;
                                    end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                                        err   <= 2'd3;
                                        busy  <= 1'b0;
                                        state <= DONE;
                                    end else begin
                                        poll_cnt <= poll_cnt + 1'b1;
                                        state    <= GAP;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
                GAP: begin
                    state   <= POLL;
                    psel    <= 1'b1;
                    penable <= 1'b0;
                    pwrite  <= 1'b0;
                    paddr   <= ADDR_STAT;
                    pwdata  <= '0;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ETH_TXSEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_ok  <= '0;
            frames_err <= '0;
            bytes_ok   <= '0;
        end else if (state == DONE) begin
            if (err == 2'd0) begin
                frames_ok <= frames_ok + 16'd1;
                bytes_ok  <= bytes_ok + {16'h0000, byte_cnt};
            end else begin
                frames_err <= frames_err + 16'd1;
            end
        end
    end
`endif

endmodule
